// File: rtl/hiscore_upload_if.sv
`default_nettype none
// ============================================================================
//  Module      : hiscore_upload_if
//  Description : HPS ioctl upload channel plus core RAM access port seen by
//                the hiscore upload responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hiscore_upload_if;
    // HPS ioctl side
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    // core RAM side
    logic        ram_access;
    logic        ram_grant;
    logic [15:0] ram_address;
    logic        ram_rd;
    logic [7:0]  ram_data;
    // status
    logic        active;

    // The responder block itself
    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, ram_grant, ram_data,
        output ioctl_din, ioctl_wait, ram_access, ram_address, ram_rd, active
    );

    // The HPS / core environment driving the responder
    modport master (
        output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, ram_grant, ram_data,
        input  ioctl_din, ioctl_wait, ram_access, ram_address, ram_rd, active
    );
endinterface
`default_nettype wire

// File: rtl/hiscore_upload.sv
`default_nettype none
// ============================================================================
//  Module      : hiscore_upload
//  Description : Upload-side responder for the HPS ioctl channel. Pauses the
//                core through a request/grant handshake and serves bytes of a
//                work-RAM window onto ioctl_din, one per HPS read strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module hiscore_upload #(
    parameter logic [7:0]  UPLOAD_INDEX  = 8'd4,
    parameter logic [15:0] BASE_ADDR     = 16'h6000,
    parameter logic [15:0] LENGTH        = 16'h0400,
    parameter int unsigned RD_LATENCY    = 2,
    parameter logic [15:0] GRANT_TIMEOUT = 16'd4800
) (
    input  logic            clk_sys,
    input  logic            reset,
    hiscore_upload_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_READY   = 3'd2,
        S_FETCH   = 3'd3,
        S_HOLD    = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    localparam logic [2:0]  c_LAT_LAST   = 3'(RD_LATENCY);
    localparam logic [15:0] c_TIMER_LAST = GRANT_TIMEOUT - 16'd1;
    localparam logic [24:0] c_LENGTH_EXT = {9'd0, LENGTH};

    state_t      r_state;
    state_t      w_next;

    logic        r_sel_q;       // previous sel, for rising-edge detection
    logic        r_pend;        // a read strobe arrived while not able to serve it
    logic        r_wait_hold;   // keeps wait high the cycle after a read is taken
    logic        r_degraded;    // grant never came: answer 8'hFF without touching RAM
    logic [2:0]  r_lat;         // cycles spent in FETCH
    logic [15:0] r_timer;       // cycles spent waiting for grant
    logic [15:0] r_ram_addr;
    logic [7:0]  r_din;

    logic        w_sel;
    logic        w_out_of_window;
    logic        w_in_session;
    logic        w_rd_window;
    logic        w_start;
    logic        w_enter_req;
    logic        w_pend_set;
    logic        w_serve;
    logic        w_timeout;
    logic        w_capture;

    assign w_sel           = bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
    assign w_out_of_window = (bus.ioctl_addr >= c_LENGTH_EXT);
    assign w_in_session    = (r_state == S_REQ) || (r_state == S_READY) ||
                             (r_state == S_FETCH) || (r_state == S_HOLD);
    assign w_rd_window     = (r_state == S_REQ) || (r_state == S_READY);

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle event decode
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_enter_req = 1'b0;
        w_pend_set  = 1'b0;
        w_serve     = 1'b0;
        w_timeout   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel && !r_sel_q) begin
                    w_next  = S_REQ;
                    w_start = 1'b1;
                end
            end
            S_REQ: begin
                if (!w_sel) begin
                    w_next = S_RELEASE;
                end else begin
                    w_pend_set = bus.ioctl_rd;
                    if (bus.ram_grant) begin
                        w_next = S_READY;
                    end else if (r_timer == c_TIMER_LAST) begin
                        w_next    = S_READY;
                        w_timeout = 1'b1;
                    end
                end
            end
            S_READY: begin
                if (!w_sel) begin
                    w_next = S_RELEASE;
                end else if (!bus.ram_grant && !r_degraded) begin
                    // Lost the RAM port: re-request before serving anything
                    w_next      = S_REQ;
                    w_enter_req = 1'b1;
                    w_pend_set  = bus.ioctl_rd;
                end else if (bus.ioctl_rd || r_pend) begin
                    w_serve = 1'b1;
                    w_next  = (w_out_of_window || r_degraded) ? S_HOLD : S_FETCH;
                end
            end
            S_FETCH: begin
                if (!w_sel) begin
                    w_next = S_RELEASE;
                end else if (r_lat == c_LAT_LAST) begin
                    w_capture = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_sel) begin
                    w_next = S_RELEASE;
                end else if (!bus.ram_grant && !r_degraded) begin
                    w_next      = S_REQ;
                    w_enter_req = 1'b1;
                end else begin
                    w_next = S_READY;
                end
            end
            S_RELEASE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: timer, pending read, latency counter, address and data capture
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sel_q     <= 1'b1;    // a session already open at reset must re-rise
            r_pend      <= 1'b0;
            r_wait_hold <= 1'b0;
            r_degraded  <= 1'b0;
            r_lat       <= 3'd0;
            r_timer     <= 16'd0;
            r_ram_addr  <= 16'd0;
            r_din       <= 8'hFF;
        end else begin
            r_sel_q     <= w_sel;
            r_wait_hold <= w_serve;

            if (w_start || w_enter_req) begin
                r_timer <= 16'd0;
            end else if (r_state == S_REQ) begin
                r_timer <= r_timer + 16'd1;
            end

            if (w_start) begin
                r_degraded <= 1'b0;
            end else if (w_timeout) begin
                r_degraded <= 1'b1;
            end

            if ((w_next == S_RELEASE) || w_serve) begin
                r_pend <= 1'b0;
            end else if (w_pend_set) begin
                r_pend <= 1'b1;
            end

            if ((r_state == S_FETCH) && (w_next == S_FETCH)) begin
                r_lat <= r_lat + 3'd1;
            end else begin
                r_lat <= 3'd0;
            end

            if (w_serve) begin
                if (w_out_of_window || r_degraded) begin
                    r_din <= 8'hFF;
                end else begin
                    r_ram_addr <= BASE_ADDR + bus.ioctl_addr[15:0];
                end
            end else if (w_capture) begin
                r_din <= bus.ram_data;
            end
        end
    end

    assign bus.ram_access  = w_in_session;
    assign bus.ram_rd      = (r_state == S_FETCH) && (r_lat == 3'd0);
    assign bus.ram_address = r_ram_addr;
    assign bus.ioctl_din   = r_din;
    assign bus.active      = (r_state != S_IDLE);
    // Wait rises with the strobe itself, then is held by state until the byte is ready
    assign bus.ioctl_wait  = w_in_session &&
                             (r_pend || r_wait_hold || (r_state == S_FETCH) ||
                              (bus.ioctl_rd && w_rd_window));

endmodule
`default_nettype wire

// File: tb/tb_hiscore_upload.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hiscore_upload
//  Description : Self-checking bench for hiscore_upload. A behavioural RAM
//                and a byte/latency model predict every read result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hiscore_upload;

    localparam int          L      = 2;
    localparam logic [15:0] BASE   = 16'h6000;
    localparam logic [15:0] LENGTH = 16'h0400;
    localparam logic [15:0] GTO    = 16'd4800;

    logic clk_sys = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_q [$];
    logic [16:0] pipe [0:L];
    logic [7:0]  last_din;

    hiscore_upload_if bus ();

    hiscore_upload #(
        .UPLOAD_INDEX  (8'd4),
        .BASE_ADDR     (BASE),
        .LENGTH        (LENGTH),
        .RD_LATENCY    (L),
        .GRANT_TIMEOUT (GTO)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Byte the HPS must receive for a given address
    function automatic logic [7:0] exp_byte(input logic [24:0] a, input bit deg);
        logic [15:0] ra;
        if (deg || (a >= {9'd0, LENGTH})) return 8'hFF;
        ra = BASE + a[15:0];
        return mem[ra];
    endfunction

    // Core RAM: data for a read is present only during the cycle L after ram_rd
    always @(negedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i <= L; i++) pipe[i] = 17'd0;
            bus.ram_data = 8'h00;
        end else begin
            for (int i = L; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = {bus.ram_rd, bus.ram_address};
            bus.ram_data = pipe[L][16] ? mem[pipe[L][15:0]] : 8'($urandom);
        end
    end

    // Every-cycle compare: RAM reads match the expected address stream
    always @(negedge clk_sys) begin
        if (bus.ram_rd) begin
            chk("rd_has_grant", 32'(bus.ram_access & bus.ram_grant), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ram_rd: got addr 0x%0h, expected no read", bus.ram_address);
            end else begin
                chk("ram_address", 32'(bus.ram_address), 32'(exp_q.pop_front()));
            end
        end
        if (!bus.active)
            chk("idle_quiet", 32'({bus.ram_access, bus.ioctl_wait, bus.ram_rd}), 32'd0);
    end

    task automatic wait_low(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (bus.ioctl_wait && (n < bound));
    endtask

    task automatic do_read(input logic [24:0] a, input bit deg, input int exp_lat);
        logic [7:0] e;
        int         n;
        e = exp_byte(a, deg);
        if (!deg && (a < {9'd0, LENGTH})) exp_q.push_back(BASE + a[15:0]);
        @(posedge clk_sys); #1;
        bus.ioctl_addr = a;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        chk("wait_on_rd", 32'(bus.ioctl_wait), 32'd1);
        @(posedge clk_sys); #1;
        bus.ioctl_rd = 1'b0;
        wait_low(200, n);
        if (exp_lat >= 0) chk("rd_latency", 32'(n), 32'(exp_lat));
        else              chk("rd_done", 32'(bus.ioctl_wait), 32'd0);
        chk("rd_data", 32'(bus.ioctl_din), 32'(e));
        last_din = e;
    endtask

    task automatic open_session();
        @(posedge clk_sys); #1;
        bus.ioctl_index  = 8'd4;
        bus.ioctl_upload = 1'b1;
    endtask

    task automatic close_session();
        @(posedge clk_sys); #1;
        bus.ioctl_upload = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("closed_active", 32'(bus.active), 32'd0);
        bus.ram_grant = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] ra;
        int          n;
        int          k;
        bit          found;

        reset            = 1'b1;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'd0;
        bus.ioctl_addr   = 25'd0;
        bus.ioctl_rd     = 1'b0;
        bus.ram_grant    = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h6000] = 8'hA5;
        mem[16'h6001] = 8'h3C;

        // Reset values
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_din",    32'(bus.ioctl_din),   32'hFF);
        chk("rst_wait",   32'(bus.ioctl_wait),  32'd0);
        chk("rst_access", 32'(bus.ram_access),  32'd0);
        chk("rst_ram_rd", 32'(bus.ram_rd),      32'd0);
        chk("rst_addr",   32'(bus.ram_address), 32'd0);
        chk("rst_active", 32'(bus.active),      32'd0);
        reset = 1'b0;

        // Foreign index: block stays idle
        @(posedge clk_sys); #1;
        bus.ioctl_index  = 8'd3;
        bus.ioctl_upload = 1'b1;
        repeat (6) begin
            @(negedge clk_sys);
            chk("foreign_idle", 32'({bus.active, bus.ram_access, bus.ioctl_din}), 32'h0FF);
        end
        @(posedge clk_sys); #1;
        bus.ioctl_upload = 1'b0;
        @(posedge clk_sys); #1;
        bus.ioctl_index = 8'd4;

        // Basic read
        open_session();
        @(negedge clk_sys);
        chk("access_same_cycle", 32'(bus.ram_access), 32'd0);
        @(negedge clk_sys);
        chk("access_next_cycle", 32'({bus.ram_access, bus.active}), 32'h3);
        repeat (9) @(posedge clk_sys);
        #1 bus.ram_grant = 1'b1;
        do_read(25'd0, 1'b0, 4);
        chk("basic_din0", 32'(bus.ioctl_din), 32'hA5);
        do_read(25'd1, 1'b0, 4);
        chk("basic_din1", 32'(bus.ioctl_din), 32'h3C);

        // Window boundary
        do_read(25'h3FF, 1'b0, 2 + L);
        do_read(25'h400, 1'b0, 2);
        chk("oow_din", 32'(bus.ioctl_din), 32'hFF);

        // Random reads, inside and outside the window
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 25'($urandom);
                1:       ra = 25'($urandom_range(32'h0400, 32'hFFFF));
                default: ra = 25'($urandom_range(0, 32'h03FF));
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk_sys);
            do_read(ra, 1'b0, (ra < {9'd0, LENGTH}) ? 2 + L : 2);
        end

        // Grant lost in READY: read waits for a new grant
        @(posedge clk_sys); #1;
        bus.ram_grant = 1'b0;
        fork
            do_read(25'h010, 1'b0, -1);
            begin
                repeat (6) @(posedge clk_sys);
                #1 bus.ram_grant = 1'b1;
            end
        join

        // Upload ends mid-fetch: nothing captured
        mem[BASE + 16'd7] = ~last_din;
        exp_q.push_back(BASE + 16'd7);
        @(posedge clk_sys); #1;
        bus.ioctl_addr = 25'd7;
        bus.ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        bus.ioctl_rd = 1'b0;
        @(negedge clk_sys);
        chk("midfetch_ram_rd", 32'(bus.ram_rd), 32'd1);
        @(posedge clk_sys); #1;
        bus.ioctl_upload = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("end_access_wait", 32'({bus.ram_access, bus.ioctl_wait}), 32'd0);
        chk("end_active_hold", 32'(bus.active), 32'd1);
        @(negedge clk_sys);
        chk("end_active_low", 32'(bus.active), 32'd0);
        chk("end_din_kept", 32'(bus.ioctl_din), 32'(last_din));
        repeat (4) @(negedge clk_sys);
        chk("end_din_still", 32'(bus.ioctl_din), 32'(last_din));
        bus.ram_grant = 1'b0;

        // Early read: issued while waiting for grant
        open_session();
        repeat (2) @(posedge clk_sys);
        exp_q.push_back(BASE);
        #1;
        bus.ioctl_addr = 25'd0;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        chk("early_wait_rise", 32'(bus.ioctl_wait), 32'd1);
        @(posedge clk_sys); #1;
        bus.ioctl_rd = 1'b0;
        repeat (20) begin
            @(negedge clk_sys);
            chk("early_wait_held", 32'(bus.ioctl_wait), 32'd1);
        end
        @(posedge clk_sys); #1;
        bus.ram_grant = 1'b1;
        found = 1'b0;
        k     = 0;
        for (int i = 0; (i < 10) && !found; i++) begin
            @(negedge clk_sys);
            if (bus.ram_rd) begin
                found = 1'b1;
                k     = i;
            end
        end
        chk("early_rd_seen", 32'(found), 32'd1);
        chk("early_rd_cycle", 32'(k), 32'd2);
        wait_low(50, n);
        chk("early_din", 32'(bus.ioctl_din), 32'hA5);
        close_session();

        // Grant timeout: degraded session answers 8'hFF
        open_session();
        @(posedge clk_sys);
        @(posedge clk_sys); #1;
        bus.ioctl_addr = 25'd5;
        bus.ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        bus.ioctl_rd = 1'b0;
        wait_low(6000, n);
        chk("timeout_min", 32'((n + 2) >= int'(GTO)), 32'd1);
        chk("timeout_max", 32'((n + 2) <= int'(GTO) + 10), 32'd1);
        chk("timeout_din", 32'(bus.ioctl_din), 32'hFF);
        do_read(25'd0, 1'b1, 2);
        close_session();

        // Session for the reset test
        open_session();
        repeat (2) @(posedge clk_sys);
        #1 bus.ram_grant = 1'b1;
        do_read(25'd2, 1'b0, 2 + L);
        exp_q.push_back(BASE + 16'd3);
        @(posedge clk_sys); #1;
        bus.ioctl_addr = 25'd3;
        bus.ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        bus.ioctl_rd = 1'b0;
        @(negedge clk_sys);
        chk("prereset_ram_rd", 32'(bus.ram_rd), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset_outputs", 32'({bus.ram_access, bus.ioctl_wait, bus.active}), 32'd0);
        chk("areset_din", 32'(bus.ioctl_din), 32'hFF);
        @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk_sys);
            chk("post_reset_idle", 32'(bus.active), 32'd0);
        end
        @(posedge clk_sys); #1;
        bus.ioctl_upload = 1'b0;
        repeat (2) @(posedge clk_sys);
        open_session();
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("rerise_active", 32'(bus.active), 32'd1);
        do_read(25'd1, 1'b0, 2 + L);
        close_session();

        repeat (4) @(negedge clk_sys);
        chk("no_missing_ram_rd", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
